// File: rtl/pc_sequencer.sv
// Program counter sequencer: sequential fetch, branch/jump/register redirects,
// exception entry and return, and a single-entry latch that holds a redirect
// seen during a stall until the stall releases.
module pc_sequencer #(
  parameter int          ADDR_W   = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC  = 32'h0000_4180
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch,
  input  logic              jtype,
  input  logic              jr,
  input  logic              exc,
  input  logic              eret,
  input  logic [25:0]       imm26,
  input  logic [ADDR_W-1:0] reg_jump,
  input  logic [ADDR_W-1:0] epc,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc4,
  output logic              pending,
  output logic              misalign
);

  localparam logic [ADDR_W-1:0] RESET_VAL = RESET_PC[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] EXC_VAL   = EXC_VEC[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] FOUR      = {{(ADDR_W-3){1'b0}}, 3'd4};

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] target_q, target_d;
  logic              pending_q, pending_d;

  logic [ADDR_W-1:0] branchOffset;
  logic [ADDR_W-1:0] branchTarget;
  logic [ADDR_W-1:0] jumpTarget;
  logic [ADDR_W-1:0] redirTarget;
  logic              redirect;

  assign pc4          = pc_q + FOUR;
  assign branchOffset = {{(ADDR_W-18){imm26[15]}}, imm26[15:0], 2'b00};
  assign branchTarget = pc4 + branchOffset;
  assign redirect     = branch | jtype | jr;

  // A 28-bit PC has no upper region bits to keep for j/jal.
  generate
    if (ADDR_W > 28) begin : gWideJump
      assign jumpTarget = {pc_q[ADDR_W-1:28], imm26, 2'b00};
    end else begin : gNarrowJump
      assign jumpTarget = {imm26, 2'b00};
    end
  endgenerate

  // Redirect target selection: branch wins over jtype, which wins over jr.
  always_comb begin
    redirTarget = reg_jump;
    if (branch) begin
      redirTarget = branchTarget;
    end else if (jtype) begin
      redirTarget = jumpTarget;
    end
  end

  // Next-state priority: exc, eret, stall, fresh redirect, latched redirect, pc+4.
  always_comb begin
    pc_d      = pc_q;
    target_d  = target_q;
    pending_d = pending_q;
    if (exc) begin
      pc_d      = EXC_VAL;
      pending_d = 1'b0;
    end else if (eret) begin
      pc_d      = epc;
      pending_d = 1'b0;
    end else if (stall) begin
      if (redirect) begin
        target_d  = redirTarget;
        pending_d = 1'b1;
      end
    end else if (redirect) begin
      pc_d      = redirTarget;
      pending_d = 1'b0;
    end else if (pending_q) begin
      pc_d      = target_q;
      pending_d = 1'b0;
    end else begin
      pc_d = pc4;
    end
  end

  // State registers with asynchronous reset to the boot address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= RESET_VAL;
      target_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      target_q  <= target_d;
      pending_q <= pending_d;
    end
  end

  assign pc       = pc_q;
  assign pending  = pending_q;
  assign misalign = |pc_q[1:0];

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios with literal
// expectations, randomized traffic against a behavioural model, and a 28-bit
// build exercising address wrap.
module tb_pc_sequencer;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0, branch = 1'b0, jtype = 1'b0, jr = 1'b0;
  logic        exc = 1'b0, eret = 1'b0;
  logic [25:0] imm26 = '0;
  logic [31:0] reg_jump = '0, epc = '0;
  logic [31:0] pc, pc4;
  logic        pending, misalign;

  logic        jr2 = 1'b0;
  logic [27:0] regJump2 = '0;
  logic [27:0] pc2, pc42;
  logic        pending2, misalign2;

  int checks = 0;
  int errors = 0;
  bit checkEn = 1'b0;

  logic [31:0] mPc;
  logic [31:0] mTarget;
  bit          mPending;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall), .branch(branch), .jtype(jtype),
    .jr(jr), .exc(exc), .eret(eret), .imm26(imm26), .reg_jump(reg_jump),
    .epc(epc), .pc(pc), .pc4(pc4), .pending(pending), .misalign(misalign)
  );

  pc_sequencer #(.ADDR_W(28)) dut28 (
    .clk(clk), .reset(reset), .stall(1'b0), .branch(1'b0), .jtype(1'b0),
    .jr(jr2), .exc(1'b0), .eret(1'b0), .imm26(26'd0), .reg_jump(regJump2),
    .epc(28'd0), .pc(pc2), .pc4(pc42), .pending(pending2), .misalign(misalign2)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Behavioural model: the PC rules evaluated on plain 64-bit integers.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mPc      = 32'h0000_3000;
      mTarget  = 32'h0;
      mPending = 1'b0;
    end else begin
      longint cur, tgt;
      cur = longint'(mPc);
      if (branch)
        tgt = (cur + 4 + longint'($signed(imm26[15:0])) * 4) % (64'd1 << 32);
      else if (jtype)
        tgt = (cur / (64'd1 << 28)) * (64'd1 << 28) + longint'(imm26) * 4;
      else
        tgt = longint'(reg_jump);
      if (tgt < 0) tgt = tgt + (64'd1 << 32);
      if (exc) begin
        mPc = 32'h0000_4180; mPending = 1'b0;
      end else if (eret) begin
        mPc = epc; mPending = 1'b0;
      end else if (stall) begin
        if (branch || jtype || jr) begin
          mTarget = tgt[31:0]; mPending = 1'b1;
        end
      end else if (branch || jtype || jr) begin
        mPc = tgt[31:0]; mPending = 1'b0;
      end else if (mPending) begin
        mPc = mTarget; mPending = 1'b0;
      end else begin
        cur = (cur + 4) % (64'd1 << 32);
        mPc = cur[31:0];
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Compare process: every falling edge, DUT outputs against the model.
  always @(negedge clk) begin
    if (checkEn) begin
      logic [32:0] nxt;
      nxt = {1'b0, mPc} + 33'd4;
      checkOutput("model pc", pc, mPc);
      checkOutput("model pc4", pc4, nxt[31:0]);
      checkOutput("model pending", {31'd0, pending}, {31'd0, mPending});
      checkOutput("model misalign", {31'd0, misalign}, {31'd0, (mPc[1:0] != 2'b00)});
    end
  end

  // Drive one cycle of inputs, take the edge, return just after the next fall.
  task automatic applyStimulus(input bit st, input bit br, input bit jt, input bit j,
                               input bit ex, input bit er, input logic [25:0] imm,
                               input logic [31:0] rj, input logic [31:0] ep);
    stall = st; branch = br; jtype = jt; jr = j; exc = ex; eret = er;
    imm26 = imm; reg_jump = rj; epc = ep;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 26'd0, 32'd0, 32'd0);
  endtask

  task automatic pinPc(input string name, input logic [31:0] expected);
    checkOutput({name, " dut"}, pc, expected);
    checkOutput({name, " model"}, mPc, expected);
  endtask

  initial begin
    #1 reset = 1'b1;
    @(negedge clk);
    #1 reset = 1'b0;
    checkEn = 1'b1;
    pinPc("reset pc", 32'h3000);
    checkOutput("reset pc4", pc4, 32'h3004);
    checkOutput("reset pending", {31'd0, pending}, 32'd0);
    checkOutput("reset misalign", {31'd0, misalign}, 32'd0);

    idle(); pinPc("seq1", 32'h3004);
    idle(); pinPc("seq2", 32'h3008);
    idle(); pinPc("seq3", 32'h300C);
    idle(); pinPc("seq4", 32'h3010);

    applyStimulus(0, 1, 0, 0, 0, 0, 26'h000FFFE, 32'd0, 32'd0);
    pinPc("branch back", 32'h300C);
    applyStimulus(0, 0, 0, 1, 0, 0, 26'd0, 32'h3000, 32'd0);
    pinPc("jr 3000", 32'h3000);
    applyStimulus(0, 0, 1, 0, 0, 0, 26'h0000C40, 32'd0, 32'd0);
    pinPc("jtype", 32'h3100);

    applyStimulus(0, 0, 0, 1, 0, 0, 26'd0, 32'h3020, 32'd0);
    applyStimulus(1, 0, 0, 1, 0, 0, 26'd0, 32'h3400, 32'd0);
    pinPc("stall hold", 32'h3020);
    checkOutput("stall pending", {31'd0, pending}, 32'd1);
    applyStimulus(1, 0, 0, 0, 0, 0, 26'd0, 32'd0, 32'd0);
    applyStimulus(1, 0, 0, 0, 0, 0, 26'd0, 32'd0, 32'd0);
    pinPc("stall held", 32'h3020);
    checkOutput("stall held pending", {31'd0, pending}, 32'd1);
    idle();
    pinPc("stall release", 32'h3400);
    checkOutput("release pending", {31'd0, pending}, 32'd0);

    applyStimulus(0, 0, 0, 1, 0, 0, 26'd0, 32'h3020, 32'd0);
    applyStimulus(1, 0, 0, 1, 0, 0, 26'd0, 32'h3400, 32'd0);
    applyStimulus(0, 1, 0, 0, 0, 0, 26'h0000004, 32'd0, 32'd0);
    pinPc("new beats latched", 32'h3034);
    checkOutput("new beats pending", {31'd0, pending}, 32'd0);
    idle(); pinPc("after override", 32'h3038);

    applyStimulus(1, 0, 0, 1, 0, 0, 26'd0, 32'h3400, 32'd0);
    applyStimulus(1, 1, 0, 0, 1, 1, 26'h0000004, 32'd0, 32'h3022);
    pinPc("exc entry", 32'h4180);
    checkOutput("exc pending", {31'd0, pending}, 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 1, 26'd0, 32'd0, 32'h3022);
    pinPc("eret", 32'h3022);
    checkOutput("eret misalign", {31'd0, misalign}, 32'd1);
    idle(); pinPc("after eret", 32'h3026);

    applyStimulus(1, 0, 0, 1, 0, 0, 26'd0, 32'h3400, 32'd0);
    checkOutput("pre-reset pending", {31'd0, pending}, 32'd1);
    #1 reset = 1'b1;
    #1;
    checkOutput("async reset pc", pc, 32'h3000);
    checkOutput("async reset pending", {31'd0, pending}, 32'd0);
    #1 reset = 1'b0;
    idle(); pinPc("post reset", 32'h3004);

    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2,
                    $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 2,
                    $urandom_range(0, 49) == 0, $urandom_range(0, 29) == 0,
                    26'($urandom), $urandom, $urandom);
    end
    idle();

    checkEn = 1'b0;
    jr2 = 1'b1; regJump2 = 28'hFFFFFFC;
    @(posedge clk); @(negedge clk);
    checkOutput("w28 top pc", {4'd0, pc2}, 32'h0FFFFFFC);
    checkOutput("w28 top pc4", {4'd0, pc42}, 32'h0);
    jr2 = 1'b0;
    @(posedge clk); @(negedge clk);
    checkOutput("w28 wrap pc", {4'd0, pc2}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
